// File: rtl/huffman_merge_engine_if.sv
// Leaf-input and node-output handshake bundle for huffman_merge_engine.
interface huffman_merge_engine_if #(
  parameter int SYM_W  = 8,
  parameter int FREQ_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [SYM_W-1:0]  in_sym;
  logic [FREQ_W-1:0] in_freq;
  logic              node_valid;
  logic              node_ready;
  logic [SYM_W:0]    node_left;
  logic [SYM_W:0]    node_right;
  logic [SYM_W-1:0]  node_id;
  logic [FREQ_W-1:0] node_freq;

  modport master (
    output in_valid, in_sym, in_freq, node_ready,
    input  in_ready, node_valid, node_left, node_right, node_id, node_freq
  );

  modport slave (
    input  in_valid, in_sym, in_freq, node_ready,
    output in_ready, node_valid, node_left, node_right, node_id, node_freq
  );
endinterface

// File: rtl/huffman_merge_engine.sv
// Huffman tree builder: keeps (symbol, frequency) entries in a stably sorted
// list, then repeatedly merges the two lowest entries and emits each merge
// as a tree node over a valid/ready port until only the root remains.
module huffman_merge_engine #(
  parameter int DEPTH  = 8,
  parameter int SYM_W  = 8,
  parameter int FREQ_W = 6,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   start,
  huffman_merge_engine_if.slave  bus,
  output logic [CNT_W-1:0]       count,
  output logic                   busy,
  output logic                   done,
  output logic                   sat
);

  typedef enum logic [1:0] {IDLE, LOAD, MERGE, DONE} state_t;

  state_t            state, state_nxt;
  logic              slot_leaf [DEPTH];
  logic [SYM_W-1:0]  slot_id   [DEPTH];
  logic [FREQ_W-1:0] slot_freq [DEPTH];
  logic              nxt_leaf  [DEPTH];
  logic [SYM_W-1:0]  nxt_id    [DEPTH];
  logic [FREQ_W-1:0] nxt_freq  [DEPTH];
  logic [CNT_W-1:0]  count_nxt;
  logic [SYM_W-1:0]  id_cnt, id_cnt_nxt;
  logic              sat_nxt;

  logic              accept, handshake;
  logic [FREQ_W:0]   sum;
  logic [FREQ_W-1:0] merged_freq;
  int unsigned       cnt_i, ins_pos, mrg_pos;

  assign bus.in_ready = ((state == IDLE) || (state == LOAD)) && (count < CNT_W'(DEPTH));
  assign busy         = (state == MERGE);
  assign done         = (state == DONE);
  assign accept       = bus.in_valid & bus.in_ready;
  assign handshake    = bus.node_valid & bus.node_ready;

  assign sum          = {1'b0, slot_freq[0]} + {1'b0, slot_freq[1]};
  assign merged_freq  = sum[FREQ_W] ? '1 : sum[FREQ_W-1:0];

  assign bus.node_valid = busy;
  assign bus.node_left  = busy ? {slot_leaf[0], slot_id[0]} : '0;
  assign bus.node_right = busy ? {slot_leaf[1], slot_id[1]} : '0;
  assign bus.node_id    = busy ? id_cnt : '0;
  assign bus.node_freq  = busy ? merged_freq : '0;

  // Next-state: list insert/merge, counters and FSM transitions.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    id_cnt_nxt = id_cnt;
    sat_nxt    = sat;
    cnt_i      = 32'(count);
    ins_pos    = 0;
    mrg_pos    = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      nxt_leaf[i] = slot_leaf[i];
      nxt_id[i]   = slot_id[i];
      nxt_freq[i] = slot_freq[i];
    end

    if (clear) begin
      state_nxt  = IDLE;
      count_nxt  = '0;
      id_cnt_nxt = '0;
      sat_nxt    = 1'b0;
    end else begin
      if (accept) begin
        // Insert after every existing entry with freq <= the new one (stable).
        for (int unsigned i = 0; i < DEPTH; i++)
          if (i < cnt_i && slot_freq[i] <= bus.in_freq) ins_pos = i + 1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (i == ins_pos) begin
            nxt_leaf[i] = 1'b1;
            nxt_id[i]   = bus.in_sym;
            nxt_freq[i] = bus.in_freq;
          end else if (i > ins_pos && i <= cnt_i) begin
            nxt_leaf[i] = slot_leaf[i-1];
            nxt_id[i]   = slot_id[i-1];
            nxt_freq[i] = slot_freq[i-1];
          end
        end
        count_nxt = count + 1'b1;
        if (state == IDLE) state_nxt = LOAD;
      end

      if (start && (state == IDLE || state == LOAD)) begin
        id_cnt_nxt = '0;
        state_nxt  = (count_nxt >= CNT_W'(2)) ? MERGE : DONE;
      end

      if (handshake) begin
        // Drop slots 0/1 and splice the merged node into slots 2.. in one pass:
        // new[i] comes from old[i+2] before the insert point, old[i+1] after it.
        for (int unsigned i = 2; i < DEPTH; i++)
          if (i < cnt_i && slot_freq[i] <= merged_freq) mrg_pos = i - 1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (i < mrg_pos) begin
            if (i + 2 < DEPTH) begin
              nxt_leaf[i] = slot_leaf[i+2];
              nxt_id[i]   = slot_id[i+2];
              nxt_freq[i] = slot_freq[i+2];
            end
          end else if (i == mrg_pos) begin
            nxt_leaf[i] = 1'b0;
            nxt_id[i]   = id_cnt;
            nxt_freq[i] = merged_freq;
          end else if (i + 1 < cnt_i) begin
            nxt_leaf[i] = slot_leaf[i+1];
            nxt_id[i]   = slot_id[i+1];
            nxt_freq[i] = slot_freq[i+1];
          end
        end
        count_nxt  = count - 1'b1;
        id_cnt_nxt = id_cnt + 1'b1;
        if (sum[FREQ_W]) sat_nxt = 1'b1;
        if (count == CNT_W'(2)) state_nxt = DONE;
      end
    end
  end

  // State, list and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      id_cnt <= '0;
      sat    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_leaf[i] <= 1'b0;
        slot_id[i]   <= '0;
        slot_freq[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      id_cnt <= id_cnt_nxt;
      sat    <= sat_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_leaf[i] <= nxt_leaf[i];
        slot_id[i]   <= nxt_id[i];
        slot_freq[i] <= nxt_freq[i];
      end
    end
  end

endmodule

// File: doc/huffman_merge_engine.md
# huffman_merge_engine

Parametrised Huffman tree builder. Accepts (symbol, frequency) leaves into a sorted list of DEPTH entries. On command, it repeatedly pops the two lowest-frequency entries, emits them as a tree node over a valid/ready port, and re-inserts the merged internal node in sorted position. It sits between the frequency counter and the code-length/codebook generator, and replaces the fixed 8-entry sorter with one that has flow control, stable ordering and saturation.

## Interface
- DEPTH, 8, list capacity (2..64)
- SYM_W, 8, symbol/internal-node ID width; DEPTH-1 must fit in SYM_W
- FREQ_W, 6, frequency width
- CNT_W, $clog2(DEPTH+1), derived

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush to IDLE, empty list
- in_valid  in  1  leaf offered
- in_ready  out  1  leaf accepted when in_valid & in_ready
- in_sym  in  SYM_W  leaf symbol
- in_freq  in  FREQ_W  leaf frequency
- start  in  1  begin merging (pulse)
- node_valid  out  1  merged node presented
- node_ready  in  1  consumer takes node
- node_left  out  SYM_W+1  {leaf_flag, id} of lower-ranked child
- node_right  out  SYM_W+1  {leaf_flag, id} of second child
- node_id  out  SYM_W  internal ID of new node
- node_freq  out  FREQ_W  child sum, saturated
- count  out  CNT_W  valid entries in list
- busy  out  1  state == MERGE
- done  out  1  state == DONE
- sat  out  1  sticky: any sum saturated

## Operation
- Entry = {valid, leaf, id[SYM_W], freq[FREQ_W]}. Slot 0 is lowest. Valid slots are contiguous from 0.
- States: IDLE (empty), LOAD, MERGE, DONE.
- in_ready = (IDLE or LOAD) & count < DEPTH. An accepted leaf is inserted at the first slot whose freq > in_freq. Ties are stable: a new entry goes after existing equal entries. Later slots shift up by one. count += 1. IDLE moves to LOAD.
- start in IDLE/LOAD:
  - count_next >= 2: go to MERGE.
  - count_next <= 1: go to DONE.
  - start is ignored in MERGE/DONE.
- MERGE:
  - node_valid = 1.
  - node_left = slot0, node_right = slot1.
  - node_id = internal ID counter, which starts at 0 each run.
  - node_freq = slot0.freq + slot1.freq computed at FREQ_W+1 bits. Overflow gives all-ones and sets sat.
- Merge handshake (node_valid & node_ready), all in the same cycle:
  - Slots 2.. shift down by 2.
  - {leaf=0, node_id, node_freq} is inserted stably among them.
  - count -= 1, ID counter += 1.
  - If count becomes 1, go to DONE.
- DONE: slot0 holds the root. DONE holds until clear or rst.
- When node_valid = 0, all node_* outputs are driven 0.
- Priority: rst > clear > insert > start. If insert and start fall in the same cycle, both act, and start evaluates the count including the new leaf.
- clear empties the list, zeroes the ID counter and sat, and returns to IDLE.

## Timing
- Reset values:
  - in_ready = 1.
  - node_valid, node_left, node_right, node_id, node_freq, count, busy, done, sat = 0.
  - All slots invalid; state IDLE.
- Insert latency: entry is visible in the list and count the cycle after acceptance. Accepting one leaf per cycle back-to-back is legal.
- start sampled at edge N gives busy = node_valid = 1 from cycle N+1.
- Throughput is one node per cycle while node_ready is held high. N leaves produce exactly N-1 nodes.
- Backpressure: while node_valid & !node_ready, every node_* output and the list hold stable.
- done rises the cycle after the final handshake, and busy falls in that same cycle.
- rst asserted mid-MERGE forces reset values immediately, without waiting for clk. Any node in flight is lost.
- in_ready = 0 throughout MERGE and DONE, and whenever the list is full.

## Test plan
- Load sym0..4 with freqs 5,2,9,2,7, then start; expect:
  - list order after load: 1,3,0,4,2;
  - nodes: (L1,L3)->n0 f4; (n0,L0)->n1 f9; (L4,L2)->n2 f16; (n1,n2)->n3 f25;
  - then done=1, count=1.
- Offer 9 leaves at DEPTH=8 with in_valid held: in_ready drops after the 8th, the 9th is never accepted, count=8. Merge gives 7 nodes.
- Freqs 40,40 at FREQ_W=6: node_freq=63, sat=1, done the next cycle. clear returns sat=0, count=0.
- Hold node_ready low for 3 cycles during the first node: node_valid stays 1 and the fields stay constant. Release, and nodes stream one per cycle.
- start with 1 leaf loaded: done=1 the next cycle and node_valid is never asserted. start with an empty list: DONE, count=0.
- Assert rst during the second merge node: the next sampled outputs are all reset values and in_ready=1. A fresh load then works.
